// File: rtl/cd_sector_responder.sv
// cd_sector_responder
//   Responder end of the CDIC sector request interface. Each accepted request
//   is answered with one raw 2352-byte sector (WORDS_PER_SECTOR 16-bit words)
//   read from a disc image in SDRAM, or with zero words when no image is
//   mounted or the LBA lies beyond the end of the image.
//
// Ports
//   clk, reset          system clock, asynchronous active-high reset
//   cd_hps_lba/req      request LBA and request line (rising edge = request)
//   cd_hps_ack          one-cycle pulse per accepted request
//   cd_hps_data_valid   one-cycle strobe per sector word
//   cd_hps_data         sector word (meaningful while data_valid=1)
//   img_mounted         disc image present
//   img_sectors         image size in sectors
//   mem_addr/mem_rd     SDRAM byte address and single-cycle read request
//   mem_busy            read port busy, mem_rd is held off while set
//   mem_dout/mem_valid  read data and its one-cycle valid
module cd_sector_responder #(
  parameter logic [24:0] BASE_ADDR        = 25'h1000000,
  parameter int unsigned WORDS_PER_SECTOR = 1176,
  parameter int unsigned WORD_GAP         = 3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] cd_hps_lba,
  input  logic        cd_hps_req,
  output logic        cd_hps_ack,
  output logic        cd_hps_data_valid,
  output logic [15:0] cd_hps_data,
  input  logic        img_mounted,
  input  logic [31:0] img_sectors,
  output logic [24:0] mem_addr,
  output logic        mem_rd,
  input  logic        mem_busy,
  input  logic [15:0] mem_dout,
  input  logic        mem_valid
);

  localparam int unsigned CW = $clog2(WORDS_PER_SECTOR + 1);
  localparam int unsigned GW = (WORD_GAP > 1) ? $clog2(WORD_GAP) : 1;
  localparam logic [CW-1:0] LAST_WORD = CW'(WORDS_PER_SECTOR - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_ACK, S_FETCH, S_WAIT, S_EMIT, S_GAP, S_DONE
  } state_t;

  state_t        state;
  logic          req_q;
  logic          start;
  logic          pending;
  logic          zero_fill;
  logic          zf_now;
  logic [31:0]   lba;
  logic [31:0]   pend_lba;
  logic [CW-1:0] word;
  logic [GW-1:0] gap_cnt;
  logic [24:0]   lba25;
  logic [24:0]   sector_off;

  assign start  = cd_hps_req && !req_q;
  assign zf_now = !img_mounted || (lba >= img_sectors);

  // lba * 2352 as 2048 + 256 + 32 + 16, wrapping at 2^25
  assign lba25      = lba[24:0];
  assign sector_off = (lba25 << 11) + (lba25 << 8) + (lba25 << 5) + (lba25 << 4);

  // The read strobe is gated by the live busy input so that it can never
  // coincide with mem_busy=1; the address behind it is registered.
  assign mem_rd = (state == S_FETCH) && !mem_busy;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state             <= S_IDLE;
      req_q             <= 1'b0;
      pending           <= 1'b0;
      pend_lba          <= '0;
      lba               <= '0;
      zero_fill         <= 1'b0;
      word              <= '0;
      gap_cnt           <= '0;
      mem_addr          <= '0;
      cd_hps_ack        <= 1'b0;
      cd_hps_data_valid <= 1'b0;
      cd_hps_data       <= '0;
    end else begin
      req_q             <= cd_hps_req;
      cd_hps_ack        <= 1'b0;
      cd_hps_data_valid <= 1'b0;

      // Requests arriving while busy park in a one-deep slot; newest wins.
      if (start && state != S_IDLE) begin
        pending  <= 1'b1;
        pend_lba <= cd_hps_lba;
      end

      case (state)
        S_IDLE: begin
          if (start) begin
            lba        <= cd_hps_lba;
            cd_hps_ack <= 1'b1;
            state      <= S_ACK;
          end
        end

        S_ACK: begin
          word      <= '0;
          zero_fill <= zf_now;
          mem_addr  <= BASE_ADDR + sector_off;
          if (zf_now) begin
            cd_hps_data       <= '0;
            cd_hps_data_valid <= 1'b1;
            state             <= S_EMIT;
          end else begin
            state <= S_FETCH;
          end
        end

        S_FETCH: begin
          if (!mem_busy) state <= S_WAIT;
        end

        S_WAIT: begin
          if (mem_valid) begin
            cd_hps_data       <= mem_dout;
            cd_hps_data_valid <= 1'b1;
            state             <= S_EMIT;
          end
        end

        S_EMIT: begin
          word     <= word + CW'(1);
          mem_addr <= mem_addr + 25'd2;
          if (word == LAST_WORD) begin
            state <= S_DONE;
          end else if (WORD_GAP == 0) begin
            if (zero_fill) begin
              cd_hps_data       <= '0;
              cd_hps_data_valid <= 1'b1;
              state             <= S_EMIT;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            // GAP lasts exactly WORD_GAP cycles, counting down to zero
            gap_cnt <= GW'(WORD_GAP - 1);
            state   <= S_GAP;
          end
        end

        S_GAP: begin
          if (gap_cnt == '0) begin
            if (zero_fill) begin
              cd_hps_data       <= '0;
              cd_hps_data_valid <= 1'b1;
              state             <= S_EMIT;
            end else begin
              state <= S_FETCH;
            end
          end else begin
            gap_cnt <= gap_cnt - GW'(1);
          end
        end

        S_DONE: begin
          // A start landing in this very cycle would be parked and served
          // next, so it is taken directly; it is also the newest request.
          if (start) begin
            lba        <= cd_hps_lba;
            pending    <= 1'b0;
            cd_hps_ack <= 1'b1;
            state      <= S_ACK;
          end else if (pending) begin
            lba        <= pend_lba;
            pending    <= 1'b0;
            cd_hps_ack <= 1'b1;
            state      <= S_ACK;
          end else begin
            state <= S_IDLE;
          end
        end

        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
